// File: rtl/emap_row_sequencer.sv
// Sequencer for the 8-lane P-vector gather: slices row descriptors into address windows,
// credits the output FIFO and keeps vector writes out of rows in flight. Option: EMAP_WR_PREEMPT_EN.
module emap_row_sequencer #(
    parameter int COLS       = 20,
    parameter int ELEMS      = 8,
    parameter int ELEM_W     = 32,
    parameter int COL_W      = 32,
    parameter int MULT_W     = 32,
    parameter int ADDR_W     = 11,
    parameter int GATHER_LAT = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    desc_valid,
    output logic                    desc_ready,
    input  logic [COLS*COL_W-1:0]   desc_col_nos,
    input  logic [MULT_W-1:0]       desc_multiples,
    output logic [ELEMS*COL_W-1:0]  g_addr,
    output logic                    g_issue,
    input  logic [ELEMS*ELEM_W-1:0] g_data,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic [ELEMS*ELEM_W-1:0] row_data,
    output logic                    row_last,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [ELEMS*ELEM_W-1:0] wr_data,
    output logic                    g_wr_en,
    output logic [ADDR_W-1:0]       g_wr_addr,
    output logic [ELEMS*ELEM_W-1:0] g_wr_data,
    output logic                    busy
);
    // state   | meaning
    // S_IDLE  | waiting for a descriptor; writes may be granted
    // S_ISSUE | issuing one window per cycle while FIFO credits allow
    // S_DRAIN | all steps issued; waiting for gathers still in flight
    localparam int MAX_STEPS = (COLS + ELEMS - 1) / ELEMS;
    localparam int NPAD      = MAX_STEPS * ELEMS;
    localparam int STEP_W    = $clog2(MAX_STEPS + 1);
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W     = $clog2(GATHER_LAT + 1);
    localparam logic [COL_W-1:0] INVALID_COL = COL_W'(32'h00FF_FFFF);

    typedef enum logic [1:0] { S_IDLE, S_ISSUE, S_DRAIN } state_t;

    state_t                    state_q, state_d;
    logic [STEP_W-1:0]         k_q, k_d, steps_q, steps_d;
    logic [COL_W-1:0]          cols_q [COLS];
    logic [COL_W-1:0]          cols_d [COLS];
    logic [COL_W-1:0]          win_list [NPAD];
    logic                      rdy_q;
    logic [GATHER_LAT-1:0]     pv_q, pv_d, pl_q, pl_d;
    logic [ELEMS*ELEM_W-1:0]   fdata_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]     flast_q;
    logic [PTR_W-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [INF_W-1:0]          inflight;
    logic                      wr_grant, issue_last, push, pop, credit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < GATHER_LAT; i++) inflight = inflight + INF_W'(pv_q[i]);
    end

    assign push      = pv_q[GATHER_LAT-1];
    assign row_valid = (count_q != '0);
    assign pop       = row_valid && row_ready;
    assign row_data  = row_valid ? fdata_q[rptr_q] : '0;
    assign row_last  = row_valid && flast_q[rptr_q];
    // Credits count gathers already launched, so a push always finds room.
    assign credit    = (32'(count_q) + 32'(inflight)) < 32'(FIFO_DEPTH);
    assign busy      = (state_q != S_IDLE) || (inflight != '0);
    assign g_wr_en   = wr_grant;
    assign g_wr_addr = wr_addr;
    assign g_wr_data = wr_data;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        steps_d    = steps_q;
        cols_d     = cols_q;
        wr_ready   = 1'b0;
        desc_ready = 1'b0;
        g_issue    = 1'b0;
        issue_last = 1'b0;
        if (rdy_q && inflight == '0) begin
            if (state_q == S_IDLE) wr_ready = 1'b1;
`ifdef EMAP_WR_PREEMPT_EN
            if (state_q == S_ISSUE) wr_ready = 1'b1;
`endif
        end
        wr_grant = wr_valid && wr_ready;
        case (state_q)
            S_IDLE: begin
                desc_ready = rdy_q && !wr_grant;
                if (desc_valid && desc_ready) begin
                    for (int e = 0; e < COLS; e++)
                        cols_d[e] = desc_col_nos[(COLS-1-e)*COL_W +: COL_W];
                    if (desc_multiples == '0)
                        steps_d = STEP_W'(1);
                    else if (desc_multiples > MULT_W'(MAX_STEPS))
                        steps_d = STEP_W'(MAX_STEPS);
                    else
                        steps_d = STEP_W'(desc_multiples);
                    k_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (credit && !wr_grant) begin
                    g_issue    = 1'b1;
                    issue_last = (k_q == steps_q - STEP_W'(1));
                    if (issue_last) state_d = S_DRAIN;
                    else            k_d     = k_q + STEP_W'(1);
                end
            end
            S_DRAIN: begin
                if (inflight == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Entries past the end of the list read as the invalid code.
    always_comb begin
        for (int e = 0; e < NPAD; e++) win_list[e] = INVALID_COL;
        for (int e = 0; e < COLS; e++) win_list[e] = cols_q[e];
    end

    always_comb begin
        g_addr = {ELEMS{INVALID_COL}};
        if (state_q == S_ISSUE) begin
            for (int s = 0; s < MAX_STEPS; s++) begin
                if (k_q == STEP_W'(s)) begin
                    for (int j = 0; j < ELEMS; j++)
                        g_addr[j*COL_W +: COL_W] = win_list[s*ELEMS + ELEMS-1-j];
                end
            end
        end
    end

    always_comb begin
        pv_d    = pv_q;
        pl_d    = pl_q;
        pv_d[0] = g_issue;
        pl_d[0] = issue_last;
        for (int i = 1; i < GATHER_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pl_d[i] = pl_q[i-1];
        end
    end

    always_comb begin
        wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = pop ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            steps_q <= '0;
            rdy_q   <= 1'b0;
            pv_q    <= '0;
            pl_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            flast_q <= '0;
            for (int e = 0; e < COLS; e++) cols_q[e] <= INVALID_COL;
            for (int i = 0; i < FIFO_DEPTH; i++) fdata_q[i] <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            steps_q <= steps_d;
            rdy_q   <= 1'b1;
            pv_q    <= pv_d;
            pl_q    <= pl_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            cols_q  <= cols_d;
            if (push) begin
                fdata_q[wptr_q] <= g_data;
                flast_q[wptr_q] <= pl_q[GATHER_LAT-1];
            end
        end
    end
endmodule

// File: tb/tb_emap_row_sequencer.sv
// Self-checking bench for emap_row_sequencer: queue-based reference model compared every cycle,
// plus directed literal checks on window contents, latency, clamping, write arbitration and reset.
`timescale 1ns/1ps
module tb_emap_row_sequencer;
    localparam int COLS = 20, ELEMS = 8, ELEM_W = 32, COL_W = 32, MULT_W = 32;
    localparam int ADDR_W = 11, GATHER_LAT = 2, FIFO_DEPTH = 4;
    localparam logic [31:0] INV = 32'h00FF_FFFF;
`ifdef EMAP_WR_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b1;
    logic desc_valid = 1'b0, desc_ready;
    logic [COLS*COL_W-1:0] desc_col_nos;
    logic [MULT_W-1:0] desc_multiples = '0;
    logic [ELEMS*COL_W-1:0] g_addr;
    logic g_issue;
    logic [ELEMS*ELEM_W-1:0] g_data = '0;
    logic row_valid, row_ready = 1'b0, row_last;
    logic [ELEMS*ELEM_W-1:0] row_data;
    logic wr_valid = 1'b0, wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [ELEMS*ELEM_W-1:0] wr_data = '0;
    logic g_wr_en;
    logic [ADDR_W-1:0] g_wr_addr;
    logic [ELEMS*ELEM_W-1:0] g_wr_data;
    logic busy;

    logic [31:0] cur_cols [COLS];

    emap_row_sequencer #(.COLS(COLS), .ELEMS(ELEMS), .ELEM_W(ELEM_W), .COL_W(COL_W),
                         .MULT_W(MULT_W), .ADDR_W(ADDR_W), .GATHER_LAT(GATHER_LAT),
                         .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_col_nos(desc_col_nos), .desc_multiples(desc_multiples), .g_addr(g_addr),
        .g_issue(g_issue), .g_data(g_data), .row_valid(row_valid), .row_ready(row_ready),
        .row_data(row_data), .row_last(row_last), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .g_wr_en(g_wr_en), .g_wr_addr(g_wr_addr),
        .g_wr_data(g_wr_data), .busy(busy));

    always #5 clk = ~clk;

    always_comb begin
        for (int e = 0; e < COLS; e++) desc_col_nos[(COLS-1-e)*32 +: 32] = cur_cols[e];
    end

    int nchecks = 0, nerrs = 0;
    int n_issue = 0, n_pop = 0, n_lastpop = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: descriptor phase, in-flight gathers as countdown queue, FIFO as queue.
    int m_phase = 0;               // 0 idle, 1 issuing, 2 draining
    bit m_rdy = 1'b0;
    logic [31:0] m_cols [COLS];
    int m_steps = 0, m_k = 0;
    int inf_rem[$];
    bit inf_last[$];
    logic [255:0] fq_data[$];
    bit fq_last[$];

    function automatic logic [255:0] window(input int k);
        logic [255:0] w;
        for (int j = 0; j < 8; j++) begin
            int idx = 8*k + 7 - j;
            w[j*32 +: 32] = INV;
            if (idx < COLS) w[j*32 +: 32] = m_cols[idx];
        end
        return w;
    endfunction

    always @(negedge clk) begin : model
        bit e_wrr, e_grant, e_dr, e_iss, e_rv, e_busy;
        logic [255:0] e_addr, e_rd;
        bit e_last;
        int infl_n;
        if (!rst_n) begin
            m_phase = 0; m_rdy = 1'b0; m_k = 0; m_steps = 0;
            inf_rem.delete(); inf_last.delete(); fq_data.delete(); fq_last.delete();
            chk("rst_desc_ready", desc_ready, 0);
            chk("rst_g_issue", g_issue, 0);
            chk("rst_g_addr", g_addr, {8{INV}});
            chk("rst_row_valid", row_valid, 0);
            chk("rst_row_last", row_last, 0);
            chk("rst_row_data", row_data, 0);
            chk("rst_wr_ready", wr_ready, 0);
            chk("rst_g_wr_en", g_wr_en, 0);
            chk("rst_busy", busy, 0);
        end else begin
            infl_n  = inf_rem.size();
            e_wrr   = m_rdy && infl_n == 0 && (m_phase == 0 || (PREEMPT && m_phase == 1));
            e_grant = wr_valid && e_wrr;
            e_dr    = m_rdy && m_phase == 0 && !e_grant;
            e_iss   = m_phase == 1 && !e_grant && (fq_data.size() + infl_n < FIFO_DEPTH);
            e_addr  = (m_phase == 1) ? window(m_k) : {8{INV}};
            e_rv    = fq_data.size() > 0;
            e_rd    = e_rv ? fq_data[0] : '0;
            e_last  = e_rv && fq_last[0];
            e_busy  = m_phase != 0 || infl_n > 0;
            chk("desc_ready", desc_ready, e_dr);
            chk("g_issue", g_issue, e_iss);
            chk("g_addr", g_addr, e_addr);
            chk("row_valid", row_valid, e_rv);
            chk("row_data", row_data, e_rd);
            chk("row_last", row_last, e_last);
            chk("wr_ready", wr_ready, e_wrr);
            chk("g_wr_en", g_wr_en, e_grant);
            chk("g_wr_addr", g_wr_addr, wr_addr);
            chk("g_wr_data", g_wr_data, wr_data);
            chk("busy", busy, e_busy);
            // advance to the state after the coming edge
            if (e_rv && row_ready) begin void'(fq_data.pop_front()); void'(fq_last.pop_front()); end
            if (infl_n > 0 && inf_rem[0] == 0) begin
                fq_data.push_back(g_data);
                fq_last.push_back(inf_last[0]);
                void'(inf_rem.pop_front());
                void'(inf_last.pop_front());
            end
            foreach (inf_rem[i]) inf_rem[i] = inf_rem[i] - 1;
            if (e_iss) begin
                inf_rem.push_back(GATHER_LAT - 1);
                inf_last.push_back(m_k == m_steps - 1);
            end
            case (m_phase)
                0: if (desc_valid && e_dr) begin
                    m_cols = cur_cols;
                    if (desc_multiples == 0)      m_steps = 1;
                    else if (desc_multiples > 3)  m_steps = 3;
                    else                          m_steps = int'(desc_multiples);
                    m_k = 0;
                    m_phase = 1;
                end
                1: if (e_iss) begin
                    if (m_k == m_steps - 1) m_phase = 2;
                    else m_k = m_k + 1;
                end
                default: if (infl_n == 0) m_phase = 0;
            endcase
            m_rdy = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (g_issue) n_issue++;
            if (row_valid && row_ready) begin
                n_pop++;
                if (row_last) n_lastpop++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            g_data = rand256();
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic set_cols_seq();
        for (int e = 0; e < COLS; e++) cur_cols[e] = e;
    endtask

    task automatic set_cols_rand();
        for (int e = 0; e < COLS; e++) cur_cols[e] = $urandom;
    endtask

    task automatic send_desc(input logic [31:0] mult);
        bit ok = 1'b0;
        @(posedge clk); #1;
        desc_multiples = mult;
        desc_valid = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (desc_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        desc_valid = 1'b0;
        chk("desc_accept_timeout", ok, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (!busy && !row_valid) ok = 1'b1;
        end
        chk("idle_timeout", ok, 1);
    endtask

    initial begin
        int n0, p0, l0;
        bit ok, g_busy, g_iss;
        set_cols_seq();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // three-step row, sequential column numbers
        row_ready = 1'b1;
        n0 = n_issue; p0 = n_pop; l0 = n_lastpop;
        send_desc(3);
        @(negedge clk);
        chk("t1_issue_step0", g_issue, 1);
        chk("t1_lane7_step0", g_addr[255:224], 0);
        chk("t1_lane0_step0", g_addr[31:0], 7);
        @(negedge clk);
        chk("t1_issue_step1", g_issue, 1);
        chk("t1_lane7_step1", g_addr[255:224], 8);
        @(negedge clk);
        chk("t1_issue_step2", g_issue, 1);
        chk("t1_lane7_step2", g_addr[255:224], 16);
        chk("t1_lane4_step2", g_addr[159:128], 19);
        chk("t1_lane3_step2", g_addr[127:96], INV);
        chk("t1_lane0_step2", g_addr[31:0], INV);
        chk("t1_no_row_yet", row_valid, 0);
        @(negedge clk);
        chk("t1_first_row_valid", row_valid, 1);
        chk("t1_no_issue_drain", g_issue, 0);
        wait_idle(40);
        chk("t1_issue_count", n_issue - n0, 3);
        chk("t1_pop_count", n_pop - p0, 3);
        chk("t1_last_count", n_lastpop - l0, 1);

        // backpressure: all three rows buffered, then credit limit on the next row
        row_ready = 1'b0;
        set_cols_rand();
        n0 = n_issue;
        send_desc(3);
        repeat (10) @(negedge clk);
        chk("bp_desc_ready", desc_ready, 1);
        chk("bp_rows_buffered", row_valid, 1);
        chk("bp_issue_count", n_issue - n0, 3);
        n0 = n_issue;
        send_desc(3);
        repeat (8) @(negedge clk);
        chk("bp_credit_issues", n_issue - n0, 1);
        row_ready = 1'b1;
        wait_idle(80);
        chk("bp_resumed_issues", n_issue - n0, 3);

        // step clamp
        set_cols_rand();
        n0 = n_issue; send_desc(0); wait_idle(40);
        chk("mult0_steps", n_issue - n0, 1);
        n0 = n_issue; send_desc(7); wait_idle(40);
        chk("mult7_steps", n_issue - n0, 3);
        n0 = n_issue; send_desc(32'hFFFF_FFFF); wait_idle(40);
        chk("multmax_steps", n_issue - n0, 3);

        // write and descriptor together in idle: write wins
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_addr = ADDR_W'($urandom); wr_data = rand256();
        desc_valid = 1'b1; desc_multiples = 2;
        @(negedge clk);
        chk("col_g_wr_en", g_wr_en, 1);
        chk("col_desc_ready", desc_ready, 0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("col_desc_next", desc_ready, 1);
        @(posedge clk); #1;
        desc_valid = 1'b0;
        wait_idle(40);

        // write held while a stalled row is in progress
        row_ready = 1'b0;
        send_desc(3);
        wr_valid = 1'b1; wr_addr = ADDR_W'($urandom); wr_data = rand256();
        ok = 1'b0; g_busy = 1'b1; g_iss = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (g_wr_en) begin ok = 1'b1; g_busy = busy; g_iss = g_issue; end
        end
        chk("held_wr_granted", ok, 1);
        chk("held_wr_no_issue", g_iss, 0);
`ifndef EMAP_WR_PREEMPT_EN
        chk("held_wr_in_idle", g_busy, 0);
`endif
        @(posedge clk); #1;
        wr_valid = 1'b0;
        row_ready = 1'b1;
        wait_idle(60);

        // reset in the middle of step 1
        send_desc(3);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_g_issue", g_issue, 0);
        chk("mid_rst_row_valid", row_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_desc_ready", desc_ready, 0);
        chk("mid_rst_g_addr", g_addr, {8{INV}});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_no_row", row_valid, 0);
        end

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            desc_valid = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) desc_multiples = $urandom;
            else desc_multiples = $urandom_range(0, 4);
            if ($urandom_range(0, 7) == 0) set_cols_rand();
            row_ready = ($urandom_range(0, 9) < 7);
            wr_valid = ($urandom_range(0, 4) == 0);
            wr_addr = ADDR_W'($urandom);
            wr_data = rand256();
        end
        @(posedge clk); #1;
        desc_valid = 1'b0; wr_valid = 1'b0; row_ready = 1'b1;
        wait_idle(100);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end
endmodule
